// File: rtl/matrix_column_feeder.sv
// ---------------------------------------------------------------------------
// matrix_column_feeder
//
// Buffers one DIM x DIM operand tile, which arrives one row per accepted
// beat. On start it replays the tile column by column, one DIM-lane vector
// per cycle, and then emits DIM-1 all-zero vectors. Lane i of the output
// feeds a skew chain of depth i, and the zero vectors flush the deepest
// chain.
//
// Ports
//   Clock     in   1      sole clock, rising edge
//   Reset     in   1      synchronous, active-high
//   in_data   in   DIM*W  tile row r, lane j = A[r][j]
//   in_valid  in   1      in_data valid
//   in_ready  out  1      a row is accepted on this edge if in_valid
//   start     in   1      stream request, honoured only when a full tile is held
//   out_data  out  DIM*W  lane i = A[i][k] in column cycle k, zero when flushing
//   out_valid out  1      high on every column and flush cycle
//   out_last  out  1      high on the final out_valid cycle of a tile
//   busy      out  1      high while streaming or flushing
// ---------------------------------------------------------------------------
// state  | meaning
// LOAD   | accepting rows into the buffer, in_ready = 1
// FULL   | DIM rows held, waiting for start
// STREAM | presenting column k on out_data
// FLUSH  | presenting zero vectors so the deepest skew chain drains
// ---------------------------------------------------------------------------
module matrix_column_feeder #(
    parameter int W   = 32,
    parameter int DIM = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [DIM*W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    output logic [DIM*W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int FW = (DIM > 2) ? $clog2(DIM - 1) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(DIM - 1);
    // For DIM = 1 there is no flush phase; the value is never used then.
    localparam logic [FW-1:0] FLUSH_END = FW'((DIM > 1) ? (DIM - 2) : 0);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_row;
    logic [CW-1:0]    w_row_nxt;
    logic [CW-1:0]    r_col;
    logic [CW-1:0]    w_col_nxt;
    logic [FW-1:0]    r_flush;
    logic [FW-1:0]    w_flush_nxt;

    logic [W-1:0]     r_buf [DIM][DIM];

    logic             w_accept;
    logic [DIM*W-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic             w_last_nxt;

    logic [DIM*W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_busy;

    assign in_ready  = (r_state == LOAD);
    assign w_accept  = in_valid && in_ready;

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_flush_nxt = r_flush;
        case (r_state)
            LOAD: begin
                if (w_accept) begin
                    if (r_row == LAST_IDX) begin
                        w_row_nxt   = '0;
                        w_state_nxt = FULL;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end
            end
            FULL: begin
                if (start) begin
                    w_state_nxt = STREAM;
                    w_col_nxt   = '0;
                end
            end
            STREAM: begin
                if (r_col == LAST_IDX) begin
                    w_col_nxt = '0;
                    if (DIM == 1) begin
                        w_state_nxt = LOAD;
                        w_row_nxt   = '0;
                    end else begin
                        w_state_nxt = FLUSH;
                        w_flush_nxt = '0;
                    end
                end else begin
                    w_col_nxt = r_col + 1'b1;
                end
            end
            FLUSH: begin
                if (r_flush == FLUSH_END) begin
                    w_state_nxt = LOAD;
                    w_row_nxt   = '0;
                    w_flush_nxt = '0;
                end else begin
                    w_flush_nxt = r_flush + 1'b1;
                end
            end
            default: begin
                w_state_nxt = LOAD;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
                w_flush_nxt = '0;
            end
        endcase
    end

    // Outputs are derived from the state being entered so that the column
    // selected on the start edge is already on out_data in the next cycle.
    always_comb begin
        w_data_nxt  = '0;
        w_valid_nxt = (w_state_nxt == STREAM) || (w_state_nxt == FLUSH);
        w_last_nxt  = ((w_state_nxt == STREAM) && (DIM == 1)) ||
                      ((w_state_nxt == FLUSH) && (w_flush_nxt == FLUSH_END));
        if (w_state_nxt == STREAM) begin
            for (int i = 0; i < DIM; i++) begin
                w_data_nxt[i*W +: W] = r_buf[i][w_col_nxt];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= LOAD;
            r_row       <= '0;
            r_col       <= '0;
            r_flush     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_flush     <= w_flush_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_busy      <= w_valid_nxt;
        end
    end

    // Tile storage is deliberately not reset; a tile is only replayed after
    // DIM fresh rows have been written.
    always_ff @(posedge Clock) begin
        if (w_accept) begin
            for (int j = 0; j < DIM; j++) begin
                r_buf[r_row][j] <= in_data[j*W +: W];
            end
        end
    end

endmodule
